// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op encodings, FSM states and op-class helpers.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } md_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_high(input logic [2:0] op);
        return !op[2] && (op != MD_MUL);
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: radix-2 shift-add multiply and restoring divide sharing one
// 2*XLEN accumulator. Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   dsor;
    logic [2:0]        op_q;
    logic              neg_main;
    logic              neg_rem;

    // Operand preparation at the accepting edge
    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            early;
    logic [XLEN-1:0] early_res;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended operands multiplied modulo 2^(2*XLEN) give the exact low 2*XLEN product bits
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{s1}}, rs1} * {{XLEN{s2}}, rs2};
`endif

    always_comb begin
        s1        = rs1_signed(op) & rs1[XLEN-1];
        s2        = rs2_signed(op) & rs2[XLEN-1];
        mag1      = s1 ? -rs1 : rs1;
        mag2      = s2 ? -rs2 : rs2;
        early     = 1'b0;
        early_res = '0;
        if (is_div(op) && rs2 == '0) begin
            early     = 1'b1;
            early_res = is_rem(op) ? rs1 : '1;
        end else if ((op == MD_DIV || op == MD_REM) && rs1 == INT_MIN && rs2 == '1) begin
            early     = 1'b1;
            early_res = is_rem(op) ? '0 : rs1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div(op)) begin
            early     = 1'b1;
            early_res = is_high(op) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
        end
`endif
    end

    // One iteration: mul adds into the high half then shifts right,
    // div shifts left and subtracts the divisor when it fits.
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dsor} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, dsor};
        if (is_div(op_q))
            acc_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        prod = neg_main ? -acc : acc;
        quo  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (is_div(op_q))
            final_res = is_rem(op_q) ? rem : quo;
        else
            final_res = is_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cnt      <= '0;
            acc      <= '0;
            dsor     <= '0;
            op_q     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (early) begin
                            result <= early_res;
                            done   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            acc      <= {{XLEN{1'b0}}, mag1};
                            dsor     <= mag2;
                            neg_main <= s1 ^ s2;
                            neg_rem  <= s1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        result <= final_res;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors pin a 64-bit arithmetic model,
// then randomized ops (with ignored mid-flight starts and a reset abort) run against it.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int pcyc  = 0;

    // Expected timeline of the one in-flight op; cycle offsets relative to the accepting edge
    bit          chk_en = 1'b0;
    bit          act_valid;
    int          act_e0, act_lat;
    logic [31:0] act_res, held_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, pcyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (o)
            MD_MUL:    begin p = sa * sb; return p[31:0];  end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from acceptance to done: 0 for early-outs, XLEN+1 for iterative ops
    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 0;
        if ((o == MD_DIV || o == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 0;
`endif
        return 33;
    endfunction

    // Per-cycle compare of all outputs against the expected timeline
    always @(negedge clk) begin
        int          d;
        logic        eb, ed;
        logic [31:0] er;
        if (chk_en) begin
            d  = pcyc - act_e0;
            eb = act_valid && d >= 0 && d <= act_lat;
            ed = act_valid && d == act_lat;
            er = (act_valid && d >= act_lat) ? act_res : held_res;
            chk("busy", {31'b0, busy}, {31'b0, eb});
            chk("done", {31'b0, done}, {31'b0, ed});
            chk("result", result, er);
        end
    end

    // Called at posedge+#1 with the DUT idle; the next edge accepts the op
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        rs1       = a;
        rs2       = b;
        act_e0    = pcyc + 1;
        act_lat   = exp_lat(o, a, b);
        act_res   = model(o, a, b);
        act_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
        issue(o, a, b);
        if (noise && act_lat > 8) begin
            repeat (3) begin @(posedge clk); #1; end
            start = 1'b1;
            op    = 3'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            repeat (3) begin @(posedge clk); #1; end
            start = 1'b0;
        end
        while (pcyc < act_e0 + act_lat + 1) begin @(posedge clk); #1; end
        held_res  = act_res;
        act_valid = 1'b0;
    endtask

    task automatic pin(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        chk("model", model(o, a, b), lit);
        run_op(o, a, b, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        act_valid = 1'b0;
        act_e0    = 0;
        act_lat   = 0;
        act_res   = '0;
        held_res  = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        pin(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        pin(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        pin(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pin(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        pin(MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        pin(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        pin(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        pin(MD_DIVU,   32'd7,          32'd2,         32'd3);
        pin(MD_REMU,   32'd7,          32'd2,         32'd1);
        pin(MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
        pin(MD_REM,    32'd5,          32'd0,         32'd5);
        pin(MD_DIVU,   32'hDEAD_BEEF,  32'd0,         32'hFFFF_FFFF);
        pin(MD_REMU,   32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF);
        pin(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        pin(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        pin(MD_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000);
        pin(MD_MULHU,  32'h0001_0000,  32'h0001_0000, 32'h0000_0001);

        // New operands offered mid-flight must not disturb the running op
        run_op(MD_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op(MD_DIV, 32'h8765_4321, 32'h0000_1234, 1'b1);

        // Reset during iteration 10 aborts the op with no done
        issue(MD_MUL, 32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        act_valid = 1'b0;
        held_res  = '0;
        rst_n     = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        pin(MD_MUL, 32'd3, 32'd4, 32'd12);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 100); rb = $urandom_range(1, 9); end
                3: rb = $urandom_range(1, 5) | (rb & 32'h8000_0000);
                default: ;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
